regfile16: RTL and testbench



---
 rtl/regfile_pkg.sv | 7 +
 rtl/decoder4to16.sv | 16 +
 rtl/mux16.sv | 10 +
 rtl/register.sv | 19 +
 rtl/regfile16.sv | 86 ++++++++
 tb/tb_regfile16.sv | 238 +++++++++++++++++++++++
 6 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing and address type for the 16-entry register file.
package regfile_pkg;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/decoder4to16.sv
// One-hot write-enable decode; all outputs low unless en is high.
module decoder4to16
    import regfile_pkg::*;
(
    input  logic                en,
    input  reg_addr_t           addr,
    output logic [NUM_REGS-1:0] onehot
);
    // Gating by en first keeps an unknown addr from reaching any enable when idle.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end
endmodule

// File: rtl/mux16.sv
// Generic 16:1 selector; one instance drives each register-file read port.
module mux16 #(
    parameter int N = 32
) (
    input  logic [N-1:0] d [16],
    input  logic [3:0]   sel,
    output logic [N-1:0] y
);
    assign y = d[sel];
endmodule

// File: rtl/register.sv
// N-bit storage element with load enable and asynchronous active-low clear.
module register #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    // Clear on reset, load d when enabled, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/regfile16.sv
// 16 x N register file: one synchronous write port, two combinational read
// ports, optional hardwired-zero entry 0 and optional write-to-read bypass.
module regfile16
    import regfile_pkg::*;
#(
    parameter int N       = 32,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_ena,
    input  reg_addr_t           wr_addr,
    input  logic [N-1:0]        wr_data,
    input  reg_addr_t           rd_addr0,
    output logic [N-1:0]        rd_data0,
    input  reg_addr_t           rd_addr1,
    output logic [N-1:0]        rd_data1,
    output logic [NUM_REGS-1:0] written
);
    // Entry 0 enable is masked off when it is hardwired to zero, so both the
    // data and the written flag for entry 0 ignore writes.
    localparam logic [NUM_REGS-1:0] WE_MASK = {{(NUM_REGS-1){1'b1}}, ~ZERO_R0};

    logic [NUM_REGS-1:0] dec_en;
    logic [NUM_REGS-1:0] we;
    logic [N-1:0]        reg_q [NUM_REGS];
    logic [NUM_REGS-1:0] written_q;
    logic [N-1:0]        mux_q0;
    logic [N-1:0]        mux_q1;
    logic                hit0;
    logic                hit1;

    decoder4to16 u_dec (
        .en     (wr_ena),
        .addr   (wr_addr),
        .onehot (dec_en)
    );

    assign we = dec_en & WE_MASK;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == 0 && ZERO_R0) begin : g_zero
            assign reg_q[i] = '0;
        end else begin : g_flop
            register #(.N(N)) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (we[i]),
                .d     (wr_data),
                .q     (reg_q[i])
            );
        end
    end

    // Sticky per-entry written flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
        end else begin
            written_q <= written_q | we;
        end
    end

    assign written = written_q;

    mux16 #(.N(N)) u_mux0 (
        .d   (reg_q),
        .sel (rd_addr0),
        .y   (mux_q0)
    );

    mux16 #(.N(N)) u_mux1 (
        .d   (reg_q),
        .sel (rd_addr1),
        .y   (mux_q1)
    );

    // Bypass forwards the in-flight write per port, but never onto a
    // hardwired-zero entry 0.
    assign hit0 = BYPASS && wr_ena && (rd_addr0 == wr_addr) && !(ZERO_R0 && (rd_addr0 == '0));
    assign hit1 = BYPASS && wr_ena && (rd_addr1 == wr_addr) && !(ZERO_R0 && (rd_addr1 == '0));

    assign rd_data0 = hit0 ? wr_data : mux_q0;
    assign rd_data1 = hit1 ? wr_data : mux_q1;
endmodule

// File: tb/tb_regfile16.sv
// Bench for regfile16: three instances share the input stimulus
// (default, ZERO_R0=0, BYPASS=1) and are checked against a small model.
module tb_regfile16;
    logic        clk;
    logic        rst_n;
    logic        wr_ena;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  rd_addr0;
    logic [3:0]  rd_addr1;

    logic [31:0] d_rd0, d_rd1, z_rd0, z_rd1, b_rd0, b_rd1;
    logic [15:0] d_wr, z_wr, b_wr;

    regfile16 #(.N(32), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(d_rd0), .rd_addr1(rd_addr1), .rd_data1(d_rd1),
        .written(d_wr)
    );

    regfile16 #(.N(32), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(z_rd0), .rd_addr1(rd_addr1), .rd_data1(z_rd1),
        .written(z_wr)
    );

    regfile16 #(.N(32), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut_bp (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(b_rd0), .rd_addr1(rd_addr1), .rd_data1(b_rd1),
        .written(b_wr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model / scoreboard ----------------
    logic [31:0] mdl_z  [16];   // ZERO_R0=1 instances
    logic [31:0] mdl_nz [16];   // ZERO_R0=0 instance
    logic [15:0] wz, wnz;
    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %08h", tag, obs);
        end else begin
            check_eq(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mdl_z[i]  = '0;
            mdl_nz[i] = '0;
        end
        wz  = '0;
        wnz = '0;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        #1;
    endtask

    task automatic commit();
        @(posedge clk);
        if (wr_addr != 4'd0) begin
            mdl_z[wr_addr] = wr_data;
            wz[wr_addr]    = 1'b1;
        end
        mdl_nz[wr_addr] = wr_data;
        wnz[wr_addr]    = 1'b1;
        #1;
        wr_ena = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        drive_write(a, d);
        commit();
    endtask

    // Read both ports on all instances (wr_ena must be low) and check written.
    task automatic read_check(input string tag, input logic [3:0] a0, input logic [3:0] a1);
        rd_addr0 = a0;
        rd_addr1 = a1;
        sb_push(mdl_z[a0]);  sb_push(mdl_z[a1]);
        sb_push(mdl_nz[a0]); sb_push(mdl_nz[a1]);
        sb_push(mdl_z[a0]);  sb_push(mdl_z[a1]);
        sb_push({16'h0, wz}); sb_push({16'h0, wnz});
        #1;
        sb_check({tag, "_d0"}, d_rd0);
        sb_check({tag, "_d1"}, d_rd1);
        sb_check({tag, "_z0"}, z_rd0);
        sb_check({tag, "_z1"}, z_rd1);
        sb_check({tag, "_b0"}, b_rd0);
        sb_check({tag, "_b1"}, b_rd1);
        sb_check({tag, "_wr"}, {16'h0, d_wr});
        sb_check({tag, "_wrz"}, {16'h0, z_wr});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] snap2, snap14;
        model_clear();
        rst_n    = 1'b0;
        wr_ena   = 1'b1;
        wr_addr  = 4'd5;
        wr_data  = 32'hDEADBEEF;
        rd_addr0 = 4'd5;
        rd_addr1 = 4'd5;

        // Reset holds everything at zero despite an active write.
        repeat (3) begin
            @(posedge clk);
            #1;
            sb_push(32'h0); sb_push(32'h0); sb_push(32'h0);
            sb_check("rst_rd0", d_rd0);
            sb_check("rst_rd0_nz", z_rd0);
            sb_check("rst_written", {16'h0, d_wr});
        end
        @(negedge clk);
        wr_ena = 1'b0;
        rst_n  = 1'b1;

        // Fill entries 1..15 and sweep both ports.
        for (int i = 1; i < 16; i++) do_write(i[3:0], 32'h1111_0000 + i);
        for (int a = 0; a < 16; a++) read_check("fill", a[3:0], 4'(15 - a));
        sb_push(32'h0000_FFFE);
        sb_check("fill_written_const", {16'h0, d_wr});

        // Entry 0: discarded with ZERO_R0=1, stored with ZERO_R0=0; bypass
        // must not forward onto hardwired zero.
        drive_write(4'd0, 32'hFFFFFFFF);
        rd_addr0 = 4'd0;
        #1;
        sb_push(32'h0);
        sb_check("zero_bypass_masked", b_rd0);
        commit();
        #1;
        sb_push(32'h0); sb_push(32'hFFFFFFFF); sb_push(32'h0); sb_push(32'h0000_FFFF);
        sb_check("zero_rd0", d_rd0);
        sb_check("zero_rd0_nz", z_rd0);
        sb_check("zero_written0", {31'h0, d_wr[0]});
        sb_check("zero_written_nz", {16'h0, z_wr});

        // Same-cycle read/write on entry 7.
        do_write(4'd7, 32'hA5A5A5A5);
        drive_write(4'd7, 32'h12345678);
        rd_addr1 = 4'd7;
        rd_addr0 = 4'd6;
        #1;
        sb_push(32'hA5A5A5A5); sb_push(32'h12345678); sb_push(mdl_z[6]);
        sb_check("rw_nobypass_before", d_rd1);
        sb_check("rw_bypass_before", b_rd1);
        sb_check("rw_bypass_other_port", b_rd0);
        commit();
        #1;
        sb_push(32'h12345678);
        sb_check("rw_nobypass_after", d_rd1);

        // Async reset pulse between clock edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        read_check("rst_mid", 4'd3, 4'd7);
        rst_n = 1'b1;
        do_write(4'd3, 32'h00000042);
        read_check("post_rst", 4'd3, 4'd0);
        sb_push(32'h42); sb_push(32'h0000_0008);
        sb_check("post_rst_rd0_const", d_rd0);
        sb_check("post_rst_written_const", {16'h0, d_wr});

        // Dual-port independence with idle random write-side toggling.
        do_write(4'd2, 32'hCAFE0002);
        do_write(4'd14, 32'hBEEF000E);
        snap2  = 32'hCAFE0002;
        snap14 = 32'hBEEF000E;
        @(negedge clk);
        wr_addr = 4'bxxxx;
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            wr_ena  = 1'b0;
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            @(posedge clk);
            #1;
            rd_addr0 = 4'd2;
            rd_addr1 = 4'd14;
            #1;
            sb_push(snap2); sb_push(snap14);
            sb_check("idle_rd0", d_rd0);
            sb_check("idle_rd1", d_rd1);
        end
        read_check("idle_final", 4'd2, 4'd14);

        // Random writes with model-checked readback.
        for (int k = 0; k < 40; k++) begin
            do_write(4'($urandom_range(0, 15)), $urandom);
            read_check("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_leftover: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
